// File: rtl/slice_reg_pkg.sv
// Shared definitions for the SLICE register-pair model: config field layout and loader states.
package slice_reg_pkg;

   localparam int SRMODE_B    = 0;
   localparam int GSR_DIS_B   = 1;
   localparam int REGSET_OFS  = 2;
   localparam int SEL_OFS     = 3;
   localparam int LSRMODE_OFS = 4;
   localparam int FIELD_W     = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } loader_state_e;

   function automatic int cfg_w(input int nreg);
      return FIELD_W * nreg + 2;
   endfunction

endpackage

// File: rtl/slice_cfg_loader.sv
// Serial shadow chain with bit counter and three-state loader; commits the shadow into the
// active configuration register atomically and flags malformed loads.
module slice_cfg_loader
   import slice_reg_pkg::*;
#(
   parameter int               CFG_W   = 8,
   parameter logic [CFG_W-1:0] CFG_RST = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_sdi,
   input  logic             cfg_sen,
   input  logic             cfg_commit,
   output logic             cfg_busy,
   output logic             cfg_err,
   output logic [CFG_W-1:0] cfg
);

   // Counter must reach CFG_W+1 so an over-shifted load is distinguishable from a full one.
   localparam int               CNT_W    = $clog2(CFG_W + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_W + 1);

   loader_state_e    state_q, state_d;
   logic [CFG_W-1:0] shadow_q, shadow_d;
   logic [CFG_W-1:0] cfg_q, cfg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      cfg_d    = cfg_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (cfg_sen) begin
               // First shift of a new load clears a stale error unless it collides with a commit.
               shadow_d = {shadow_q[CFG_W-2:0], cfg_sdi};
               cnt_d    = CNT_W'(1);
               err_d    = cfg_commit;
               state_d  = SHIFT;
            end else if (cfg_commit) begin
               err_d = 1'b1;
            end
         end
         SHIFT: begin
            if (cfg_sen) begin
               shadow_d = {shadow_q[CFG_W-2:0], cfg_sdi};
               if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
               if (cfg_commit) err_d = 1'b1;
            end else if (cfg_commit) begin
               if (cnt_q == CNT_FULL) begin
                  state_d = COMMIT;
               end else begin
                  err_d   = 1'b1;
                  cnt_d   = '0;
                  state_d = IDLE;
               end
            end
         end
         COMMIT: begin
            cfg_d   = shadow_q;
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         cfg_q    <= CFG_RST;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         cfg_q    <= cfg_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   assign cfg_busy = (state_q == COMMIT);
   assign cfg_err  = err_q;
   assign cfg      = cfg_q;

endmodule

// File: rtl/slice_reg_pair_model.sv
// Register half of a LIFCL SLICE: per-register GSR / LSR / CE priority mux in front of a flop,
// driven by the configuration held in the serial loader.
module slice_reg_pair_model
   import slice_reg_pkg::*;
#(
   parameter int                     NREG    = 2,
   parameter logic [cfg_w(NREG)-1:0] CFG_RST = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cfg_sdi,
   input  logic            cfg_sen,
   input  logic            cfg_commit,
   output logic            cfg_busy,
   output logic            cfg_err,
   input  logic            gsr_n,
   input  logic            ce,
   input  logic            lsr,
   input  logic [NREG-1:0] f,
   input  logic [NREG-1:0] m,
   output logic [NREG-1:0] q
);

   localparam int CFG_W = cfg_w(NREG);

   logic [CFG_W-1:0] cfg;
   logic             gsr_act;
   logic             lsr_act;

   slice_cfg_loader #(
      .CFG_W   (CFG_W),
      .CFG_RST (CFG_RST)
   ) u_loader (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_sdi    (cfg_sdi),
      .cfg_sen    (cfg_sen),
      .cfg_commit (cfg_commit),
      .cfg_busy   (cfg_busy),
      .cfg_err    (cfg_err),
      .cfg        (cfg)
   );

   // In LSR_OVER_CE mode lsr acts regardless of ce; in CE_OVER_LSR it is gated by ce.
   assign gsr_act = !cfg[GSR_DIS_B] && !gsr_n;
   assign lsr_act = lsr && (!cfg[SRMODE_B] || ce);

   for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      logic reg_q, reg_d;
      logic regset, sel, lsrmode;

      assign regset  = cfg[REGSET_OFS  + FIELD_W*gi];
      assign sel     = cfg[SEL_OFS     + FIELD_W*gi];
      assign lsrmode = cfg[LSRMODE_OFS + FIELD_W*gi];

      always_comb begin
         reg_d = reg_q;
         if (gsr_act)       reg_d = regset;
         else if (lsr_act)  reg_d = lsrmode ? m[gi] : regset;
         else if (ce)       reg_d = sel ? m[gi] : f[gi];
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) reg_q <= 1'b0;
         else        reg_q <= reg_d;
      end

      assign q[gi] = reg_q;
   end

endmodule

// File: tb/tb_slice_reg_pair_model.sv
// Scoreboard bench: a cycle-level reference model predicts q / cfg_busy / cfg_err / active config
// for every clock; a monitor compares them on the falling edge.
module tb_slice_reg_pair_model;
   import slice_reg_pkg::*;

   localparam int               NREG    = 2;
   localparam int               CFG_W   = cfg_w(NREG);
   localparam logic [CFG_W-1:0] CFG_RST = '0;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            cfg_sdi = 1'b0, cfg_sen = 1'b0, cfg_commit = 1'b0;
   logic            cfg_busy, cfg_err;
   logic            gsr_n = 1'b1, ce = 1'b0, lsr = 1'b0;
   logic [NREG-1:0] f = '0, m = '0;
   logic [NREG-1:0] q;

   slice_reg_pair_model #(.NREG(NREG), .CFG_RST(CFG_RST)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_sdi    (cfg_sdi),
      .cfg_sen    (cfg_sen),
      .cfg_commit (cfg_commit),
      .cfg_busy   (cfg_busy),
      .cfg_err    (cfg_err),
      .gsr_n      (gsr_n),
      .ce         (ce),
      .lsr        (lsr),
      .f          (f),
      .m          (m),
      .q          (q)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NREG-1:0]  q;
      logic             busy;
      logic             err;
      logic [CFG_W-1:0] cfg;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state
   logic [CFG_W-1:0] m_cfg, m_shadow;
   logic [NREG-1:0]  m_q;
   int               m_count;
   bit               m_loading, m_committing, m_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, want, $time);
      end
   endtask

   task automatic model_reset();
      m_cfg = CFG_RST; m_shadow = '0; m_q = '0; m_count = 0;
      m_loading = 0; m_committing = 0; m_err = 0;
   endtask

   task automatic model_eval();
      logic [NREG-1:0] nq;
      exp_t            e;
      for (int i = 0; i < NREG; i++) begin
         logic rs, sl, lm;
         rs = m_cfg[2 + 3*i];
         sl = m_cfg[3 + 3*i];
         lm = m_cfg[4 + 3*i];
         if (!m_cfg[1] && !gsr_n)          nq[i] = rs;
         else if (lsr && (!m_cfg[0] || ce)) nq[i] = lm ? m[i] : rs;
         else if (ce)                       nq[i] = sl ? m[i] : f[i];
         else                               nq[i] = m_q[i];
      end
      m_q = nq;
      if (m_committing) begin
         m_cfg = m_shadow; m_committing = 0; m_count = 0;
      end else if (cfg_sen) begin
         if (!m_loading) begin
            m_loading = 1; m_count = 0; m_err = cfg_commit;
         end else if (cfg_commit) begin
            m_err = 1;
         end
         m_shadow = {m_shadow[CFG_W-2:0], cfg_sdi};
         if (m_count < CFG_W + 1) m_count++;
      end else if (cfg_commit) begin
         if (m_loading && m_count == CFG_W) m_committing = 1;
         else                               m_err = 1;
         m_loading = 0; m_count = 0;
      end
      e.q = m_q; e.busy = m_committing; e.err = m_err; e.cfg = m_cfg;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      model_eval();
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (rst_n && exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("q",        32'(q),        32'(e.q));
         chk("cfg_busy", 32'(cfg_busy), 32'(e.busy));
         chk("cfg_err",  32'(cfg_err),  32'(e.err));
         chk("cfg",      32'(dut.cfg),  32'(e.cfg));
      end
   end

   task automatic set_data(input logic g, input logic c, input logic l,
                           input logic [NREG-1:0] fv, input logic [NREG-1:0] mv);
      gsr_n = g; ce = c; lsr = l; f = fv; m = mv;
   endtask

   task automatic rand_data();
      gsr_n = ($urandom_range(0, 7) != 0);
      ce    = 1'($urandom);
      lsr   = ($urandom_range(0, 3) == 0);
      f     = NREG'($urandom);
      m     = NREG'($urandom);
   endtask

   task automatic shift_bits(input logic [15:0] v, input int nbits, input bit rnd);
      for (int i = 0; i < nbits; i++) begin
         cfg_sen = 1'b1;
         cfg_sdi = v[nbits-1-i];
         if (rnd) rand_data();
         step();
      end
      cfg_sen = 1'b0;
   endtask

   task automatic commit_cfg(input bit rnd);
      cfg_commit = 1'b1;
      if (rnd) rand_data();
      step();
      cfg_commit = 1'b0;
      if (rnd) begin
         rand_data();
         cfg_sen = 1'($urandom);
         cfg_sdi = 1'($urandom);
      end
      step();
      cfg_sen = 1'b0;
   endtask

   task automatic load_cfg(input logic [CFG_W-1:0] v);
      shift_bits(16'(v), CFG_W, 1'b0);
      commit_cfg(1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      #1;
      chk("rst_q",    32'(q),        32'(0));
      chk("rst_busy", 32'(cfg_busy), 32'(0));
      chk("rst_err",  32'(cfg_err),  32'(0));
      chk("rst_cfg",  32'(dut.cfg),  32'(CFG_RST));
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      // SRMODE=1 (CE_OVER_LSR), both RESET/DF/LSR
      set_data(1, 0, 0, '0, '0);
      load_cfg(8'b000_000_01);
      set_data(1, 1, 0, 2'b11, 2'b00); step();
      set_data(1, 0, 1, 2'b00, 2'b00); step(); step();
      set_data(1, 1, 1, 2'b11, 2'b11); step();

      // SRMODE=0, REGSET0=SET, LSRMODE1=PRLD
      set_data(1, 0, 0, '0, '0);
      load_cfg(8'b100_001_00);
      set_data(1, 1, 0, 2'b00, 2'b00); step();
      set_data(1, 0, 1, 2'b00, 2'b10); step();

      // GSR with both REGSET=SET, then GSR disabled
      set_data(1, 1, 0, 2'b00, 2'b00); step();
      load_cfg(8'b001_001_00);
      set_data(0, 1, 1, 2'b00, 2'b00); step();
      set_data(0, 1, 0, 2'b00, 2'b00); step();
      set_data(1, 0, 0, '0, '0);
      load_cfg(8'b001_001_10);
      set_data(0, 1, 1, 2'b00, 2'b00); step();
      set_data(0, 1, 0, 2'b00, 2'b00); step();

      // Error paths: short load, commit in IDLE, over-shift, sen+commit collision
      set_data(1, 0, 0, '0, '0);
      shift_bits(16'h00FF, 7, 1'b0);
      commit_cfg(1'b0);
      cfg_commit = 1'b1; step(); cfg_commit = 1'b0; step();
      shift_bits(16'h01AA, 9, 1'b0);
      commit_cfg(1'b0);
      cfg_sen = 1'b1; cfg_sdi = 1'b1; step();
      cfg_commit = 1'b1; step();
      cfg_sen = 1'b0; cfg_commit = 1'b0; step();
      cfg_commit = 1'b1; step(); cfg_commit = 1'b0; step();

      // Commit-edge ordering: SEL0 DF->DL with f0=0, m0=1
      set_data(1, 0, 0, '0, '0);
      load_cfg(8'b000_000_00);
      shift_bits(16'(8'b000_010_00), CFG_W, 1'b0);
      set_data(1, 1, 0, 2'b00, 2'b01);
      cfg_commit = 1'b1; step();
      cfg_commit = 1'b0; step();
      step(); step();

      // Randomized mix of legal loads and free-running control
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 2) == 0) begin
            for (int c = 0; c < 12; c++) begin
               rand_data();
               cfg_sen    = ($urandom_range(0, 2) == 0);
               cfg_sdi    = 1'($urandom);
               cfg_commit = ($urandom_range(0, 7) == 0);
               step();
            end
            cfg_sen = 1'b0; cfg_commit = 1'b0;
            // return the loader to IDLE with a commit attempt
            commit_cfg(1'b1);
         end else begin
            shift_bits(16'($urandom), CFG_W, 1'b1);
            commit_cfg(1'b1);
         end
         for (int c = 0; c < 8; c++) begin
            rand_data();
            step();
         end
      end

      // Asynchronous reset mid-cycle, mid-load, with q driven high
      set_data(1, 1, 0, 2'b11, 2'b11);
      load_cfg(8'b000_000_00);
      step();
      cfg_sen = 1'b1; cfg_sdi = 1'b1; step(); step();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("arst_q",    32'(q),        32'(0));
      chk("arst_busy", 32'(cfg_busy), 32'(0));
      chk("arst_err",  32'(cfg_err),  32'(0));
      chk("arst_cfg",  32'(dut.cfg),  32'(CFG_RST));
      cfg_sen = 1'b0;
      set_data(1, 0, 0, '0, '0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      cfg_commit = 1'b1; step(); cfg_commit = 1'b0;
      set_data(1, 1, 0, 2'b10, 2'b01); step(); step();

      #2;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
